fetch_queue: RTL
================

# fetch_queue

Instruction fetch buffer between instruction memory and the decode stage. Each cycle it drives a fetch address to the asynchronous-read `imem`, captures the returned word with its PC into a small circular queue, and presents queued instructions to the decoder over a valid/ready handshake. The queue decouples decoder stalls from fetch and supports a single-cycle flush/redirect for taken branches.

## Interface
- WIDTH, 32, data and address width.
- DEPTH, 4, queue entries; power of two, ≥ 2.
- RESET_PC, 0, fetch address after reset.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_en  in  1  permits fetch this cycle; 0 = fetch halted.
- imem_addr  out  WIDTH  byte address to imem, equal to internal fetch PC.
- imem_rd  in  WIDTH  instruction word, combinationally valid for imem_addr in the same cycle.
- flush  in  1  discard all queued entries and redirect fetch.
- redirect_pc  in  WIDTH  new fetch PC, sampled when flush=1.
- instr  out  WIDTH  head instruction; 0 when valid=0.
- instr_pc  out  WIDTH  PC of head instruction; 0 when valid=0.
- valid  out  1  head entry present (count ≠ 0).
- ready  in  1  decoder accepts head this cycle.
- count  out  $clog2(DEPTH+1)  occupied entries, 0..DEPTH.

## Operation
- State: fetch PC register, head/tail pointers (log2 DEPTH bits, wrap mod DEPTH), occupancy counter, DEPTH×(2·WIDTH) storage.
- pop = valid & ready & ~flush.
- push = fetch_en & ~flush & (count < DEPTH | pop). Simultaneous pop lets a full queue sustain one instruction per cycle.
- On push: entry[tail] ← {imem_rd, imem_addr}; tail ← tail+1; fetch PC ← fetch PC + 4, wrapping mod 2^WIDTH.
- On pop: head ← head+1.
- count ← count + push − pop. Push and pop together leave count unchanged.
- No push while full with no pop: fetch PC holds and imem_addr repeats the same address.
- fetch_en=0: no push and PC holds. Pops continue.
- flush=1 has priority over push and pop:
  - head, tail and count ← 0.
  - fetch PC ← redirect_pc.
  - The imem_rd word present in the flush cycle is discarded.
- reset=1 has priority over flush. It clears the pointers and count and loads fetch PC ← RESET_PC. Storage contents are don't-care.
- redirect_pc is used as given. No alignment check is performed and the low two bits pass through.

## Timing
- Reset values: imem_addr=RESET_PC, instr=0, instr_pc=0, valid=0, count=0.
- Fetch-to-decode latency is 1 cycle. A word pushed at edge n is visible on instr/valid after edge n. There is no same-cycle bypass from imem_rd to instr.
- instr, instr_pc, valid and count depend only on registered state. None of them depends combinationally on ready or flush.
- After flush at edge n:
  - valid=0 and imem_addr=redirect_pc in cycle n+1.
  - The first redirected instruction appears in cycle n+2.
- Reset asserted mid-stream takes effect at the next edge. The queue empties and in-flight entries are lost.
- Steady state with ready=1 and fetch_en=1: one instruction per cycle, count stable at 1.

## Test plan
Memory model: imem_rd = imem_addr ^ 32'hE000_0000.

- Reset, then fetch_en=1, ready=1 for 5 cycles. Required response:
  - instr_pc sequence 0,4,8,12 starting in cycle 1.
  - instr = 32'hE000_0000, 32'hE000_0004, …
  - count holds at 1.
- ready=0 with fetch_en=1. Required response:
  - count climbs 1,2,3,4 and stops at 4.
  - imem_addr sticks at 16.
  - Then ready=1 for one cycle: head instr_pc 0 pops, 16 is pushed, count stays 4, next head is 4.
- Full queue with ready=1 held for DEPTH+3 cycles. Required response:
  - Pointers wrap.
  - instr_pc stays strictly sequential in steps of 4 with no gaps or duplicates.
- Flush with redirect_pc=32'h0000_0100 while count=3. Required response:
  - Next cycle: valid=0, count=0, imem_addr=0x100.
  - Following cycle: instr_pc=0x100, instr=32'hE000_0100.
  - Flush together with ready=1 pops nothing.
- fetch_en=0 for 3 cycles with ready=1 and count=2. Required response:
  - Queue drains to count=0 and valid=0.
  - imem_addr is unchanged.
  - Fetch resumes at the same address when fetch_en returns to 1.
- Assert reset while count=4 and flush=1 in the same cycle. Required response:
  - Reset wins: imem_addr=RESET_PC, count=0, valid=0.
  - PC wrap check: redirect_pc=32'hFFFF_FFFC, then push. Next instr_pc sequence is FFFF_FFFC followed by 0000_0000.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch buffer: drives imem, queues {instr, pc} pairs and hands them to decode.
// Flush redirects fetch in one cycle and drops everything queued, including the word fetched that cycle.
module fetch_queue #(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [WIDTH-1:0]           imem_addr,
  input  logic [WIDTH-1:0]           imem_rd,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           redirect_pc,
  output logic [WIDTH-1:0]           instr,
  output logic [WIDTH-1:0]           instr_pc,
  output logic                       valid,
  input  logic                       ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]    C_FULL = CW'(DEPTH);
  localparam logic [WIDTH-1:0] C_STEP = WIDTH'(4);

  logic [WIDTH-1:0] r_fetch_pc;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mem_instr [DEPTH];
  logic [WIDTH-1:0] r_mem_pc    [DEPTH];

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == C_FULL);
  assign w_pop   = w_valid & ready & ~flush;
  // A full queue may still accept a word when the head leaves in the same cycle.
  assign w_push  = fetch_en & ~flush & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (flush) begin
      r_fetch_pc <= redirect_pc;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + C_STEP;
        r_tail     <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the occupancy count gates every read.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem_instr[r_tail] <= imem_rd;
      r_mem_pc[r_tail]    <= r_fetch_pc;
    end
  end

  assign imem_addr = r_fetch_pc;
  assign valid     = w_valid;
  assign count     = r_count;
  assign instr     = w_valid ? r_mem_instr[r_head] : '0;
  assign instr_pc  = w_valid ? r_mem_pc[r_head]    : '0;

endmodule
